// File: rtl/dec_mult_pkg.sv
// Shared types and constants for the BCD-4221 multiple generator.
// Holds the FSM state encoding, the 5211 recode table and the digit-value helper.
package dec_mult_pkg;

  localparam int NDIG_DEF  = 16;
  localparam int K_MAX_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  // Entry v is the 5211 code of decimal value v; index 0 is the rightmost slice.
  localparam logic [9:0][3:0] RECODE_5211 = {
    4'b1111, 4'b1101, 4'b1100, 4'b1001, 4'b1000,
    4'b0111, 4'b0101, 4'b0100, 4'b0001, 4'b0000
  };

  function automatic logic [3:0] val4221(input logic [3:0] d);
    return {1'b0, d[3], 2'b00} + {2'b00, d[2], 1'b0} + {2'b00, d[1], 1'b0} + {3'b000, d[0]};
  endfunction

endpackage

// File: rtl/dec_digit_x2_4221.sv
// One BCD-4221 digit doubler: purely combinational, zero latency, no flow control.
// The digit is recoded to 5211; shifting that code left one place doubles it back in 4221.
module dec_digit_x2_4221
  import dec_mult_pkg::*;
(
  input  logic [3:0] i_d,
  input  logic       i_cin,
  output logic [3:0] o_d,
  output logic       o_cout
);

  logic [3:0] w_v;
  logic [3:0] w_c5211;

  assign w_v     = val4221(i_d);
  assign w_c5211 = RECODE_5211[w_v];
  assign o_d     = {w_c5211[2:0], i_cin};
  assign o_cout  = w_c5211[3];

endmodule

// File: rtl/decimal_multiple_gen.sv
// Emits 2^s*X for s=1..k_eff (or X alone when k_eff=0), one doubling per SHIFT cycle, first beat 2 edges after accept.
// Backpressure: each beat is held stable in OUT until out_ready; in_ready is high only while idle.
module decimal_multiple_gen
  import dec_mult_pkg::*;
#(
  parameter int NDIG  = NDIG_DEF,
  parameter int K_MAX = K_MAX_DEF,
  localparam int KW   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NDIG-1:0]       in_x,
  input  logic [KW-1:0]           in_k,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*(NDIG+1)-1:0]   out_w,
  output logic [KW-1:0]           out_step,
  output logic                    out_last,
  output logic                    out_ovf
);

  localparam logic [KW-1:0] KMAX_W = KW'(K_MAX);

  state_t                   r_state;
  logic [4*(NDIG+1)-1:0]    r_w;
  logic [KW-1:0]            r_s;
  logic [KW-1:0]            r_k;
  logic                     r_vld;
  logic                     r_last;
  logic                     r_ovf;

  logic [NDIG+1:0]          w_carry;
  logic [4*(NDIG+1)-1:0]    w_dbl;
  logic [KW-1:0]            w_keff;
  logic [KW-1:0]            w_s_nxt;

  // Ripple chain; the carry out of the top digit is the lost overflow.
  assign w_carry[0] = 1'b0;
  for (genvar i = 0; i <= NDIG; i++) begin : g_dig
    dec_digit_x2_4221 u_dig (
      .i_d    (r_w[4*i +: 4]),
      .i_cin  (w_carry[i]),
      .o_d    (w_dbl[4*i +: 4]),
      .o_cout (w_carry[i+1])
    );
  end

  assign w_keff  = (in_k > KMAX_W) ? KMAX_W : in_k;
  assign w_s_nxt = r_s + KW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_w     <= '0;
      r_s     <= '0;
      r_k     <= '0;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_w   <= {4'b0000, in_x};
            r_s   <= '0;
            r_k   <= w_keff;
            r_ovf <= 1'b0;
            if (w_keff == '0) begin
              r_state <= S_OUT;
              r_vld   <= 1'b1;
              r_last  <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
              r_last  <= 1'b0;
            end
          end
        end
        S_SHIFT: begin
          r_w     <= w_dbl;
          r_s     <= w_s_nxt;
          r_ovf   <= r_ovf | w_carry[NDIG+1];
          r_last  <= (w_s_nxt == r_k);
          r_vld   <= 1'b1;
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_vld   <= 1'b0;
            r_state <= r_last ? S_IDLE : S_SHIFT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_vld;
  assign out_w     = r_w;
  assign out_step  = r_s;
  assign out_last  = r_last;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_decimal_multiple_gen.sv
// Directed bench for decimal_multiple_gen: a K_MAX=3 and a K_MAX=4 instance (NDIG=4), selected by sel.
// Beats are compared on decoded digit values since the 4221 code is redundant.
module tb_decimal_multiple_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_x;
  logic [2:0]  in_k;

  logic        rdy3, vld3, last3, ovf3;
  logic [19:0] w3;
  logic [2:0]  s3;
  logic        rdy4, vld4, last4, ovf4;
  logic [19:0] w4;
  logic [2:0]  s4;

  logic        in_ready, out_valid, out_last, out_ovf;
  logic [19:0] out_w;
  logic [2:0]  out_step;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decimal_multiple_gen #(.NDIG(4), .K_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(rdy3),
    .in_x(in_x), .in_k(in_k), .out_valid(vld3), .out_ready(out_ready),
    .out_w(w3), .out_step(s3), .out_last(last3), .out_ovf(ovf3)
  );

  decimal_multiple_gen #(.NDIG(4), .K_MAX(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(rdy4),
    .in_x(in_x), .in_k(in_k), .out_valid(vld4), .out_ready(out_ready),
    .out_w(w4), .out_step(s4), .out_last(last4), .out_ovf(ovf4)
  );

  assign in_ready  = sel ? rdy4  : rdy3;
  assign out_valid = sel ? vld4  : vld3;
  assign out_w     = sel ? w4    : w3;
  assign out_step  = sel ? s4    : s3;
  assign out_last  = sel ? last4 : last3;
  assign out_ovf   = sel ? ovf4  : ovf3;

  typedef struct {
    int x;
    int k;
    int ke;
    int e0;
    int e1;
    int e2;
    int e3;
    int ovb;
    int stall;
    bit sel;
    bit alt;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int dval(input logic [19:0] w);
    int v = 0;
    for (int i = 4; i >= 0; i--)
      v = v * 10 + 4 * int'(w[4*i+3]) + 2 * int'(w[4*i+2]) + 2 * int'(w[4*i+1]) + int'(w[4*i]);
    return v;
  endfunction

  function automatic logic [15:0] enc(input int n, input bit alt);
    logic [3:0] std_c [10];
    logic [3:0] alt_c [10];
    logic [15:0] r;
    int m;
    std_c = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1110, 4'b1111};
    alt_c = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
    m = n;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = alt ? alt_c[m % 10] : std_c[m % 10];
      m = m / 10;
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v);
    int ev[4];
    int n;
    int nb;
    ev = '{v.e0, v.e1, v.e2, v.e3};
    nb = (v.ke == 0) ? 1 : v.ke;
    sel = v.sel;
    out_ready = (v.stall == 0);
    @(negedge clk);
    chk("in_ready_idle", int'(in_ready), 1);
    in_valid = 1'b1;
    in_x = enc(v.x, v.alt);
    in_k = 3'(v.k);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    for (int j = 0; j < nb; j++) begin
      int t = 0;
      while (!out_valid && t < 20) begin
        @(negedge clk);
        n++;
        t++;
      end
      if (!out_valid) begin
        chk("beat_timeout", 0, 1);
        return;
      end
      if (j == 0) chk("first_latency", n, (v.ke == 0) ? 1 : 2);
      chk("out_w", dval(out_w), ev[j]);
      chk("out_step", int'(out_step), (v.ke == 0) ? 0 : j + 1);
      chk("out_last", int'(out_last), int'(j == nb - 1));
      chk("out_ovf", int'(out_ovf), int'(j >= v.ovb));
      if (j == 0 && v.stall > 0) begin
        for (int c = 0; c < v.stall; c++) begin
          @(negedge clk);
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_w", dval(out_w), ev[0]);
          chk("stall_step", int'(out_step), 1);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      chk("beat_consumed", int'(out_valid), 0);
    end
    chk("back_idle", int'(in_ready), 1);
  endtask

  initial begin
    tv[0] = '{1234, 3, 3, 2468, 4936, 9872, 0, 99, 0, 1'b0, 1'b0};
    tv[1] = '{9999, 3, 3, 19998, 39996, 79992, 0, 99, 0, 1'b0, 1'b0};
    tv[2] = '{507, 0, 0, 507, 0, 0, 0, 99, 0, 1'b0, 1'b0};
    tv[3] = '{507, 7, 3, 1014, 2028, 4056, 0, 99, 0, 1'b0, 1'b0};
    tv[4] = '{1234, 2, 2, 2468, 4936, 0, 0, 99, 5, 1'b0, 1'b0};
    tv[5] = '{5678, 1, 1, 11356, 0, 0, 0, 99, 0, 1'b0, 1'b1};
    tv[6] = '{0, 2, 2, 0, 0, 0, 0, 99, 0, 1'b0, 1'b0};
    tv[7] = '{9999, 4, 4, 19998, 39996, 79992, 59984, 3, 0, 1'b1, 1'b0};
    tv[8] = '{1, 1, 1, 2, 0, 0, 0, 99, 0, 1'b1, 1'b0};
    tv[9] = '{4999, 7, 4, 9998, 19996, 39992, 79984, 99, 0, 1'b1, 1'b1};

    rst_n = 1'b0;
    sel = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_x = '0;
    in_k = '0;
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk("rst_out_step", int'(out_step), 0);
    chk("rst_out_w", dval(out_w), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(tv[i]);

    // Reset while the step-2 doubling is in flight.
    sel = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_x = enc(1234, 1'b0);
    in_k = 3'd3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_seq_beat1_valid", int'(out_valid), 1);
    chk("rst_seq_beat1_w", dval(out_w), 2468);
    @(negedge clk);
    chk("rst_seq_in_shift", int'(in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", int'(in_ready), 1);
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_out_step", int'(out_step), 0);
    chk("async_rst_out_w", dval(out_w), 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_hold_no_beat", int'(out_valid), 0);
    end
    rst_n = 1'b1;
    run_vec(tv[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decimal_multiple_gen.md
DECIMAL_MULTIPLE_GEN -- requirements
Module: decimal_multiple_gen

Interface
REQ-001 SHALL have parameter NDIG, default 16, the operand width in decimal digits (legal values are 1..32).
REQ-002 SHALL have parameter K_MAX, default 3, the maximum number of doublings per operation (legal values are 1..7).
REQ-003 SHALL have derived localparam KW = 3, the width of the step fields.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: operand offered.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept an operand.
REQ-008 SHALL have port in_x, input, 4*NDIG bits: operand X, BCD-4221 digits, digit i at [4i+3:4i].
REQ-009 SHALL have port in_k, input, KW bits: requested number of doublings k.
REQ-010 SHALL have port out_valid, output, 1 bit: a multiple is presented.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the presented multiple.
REQ-012 SHALL have port out_w, output, 4*(NDIG+1) bits: current multiple 2^s*X, BCD-4221 digits.
REQ-013 SHALL have port out_step, output, KW bits: the step index s of the presented multiple.
REQ-014 SHALL have port out_last, output, 1 bit: the presented multiple is the final one, s == k_eff.
REQ-015 SHALL have port out_ovf, output, 1 bit: sticky flag, a carry was lost off digit NDIG during this operation.

Function
REQ-016 SHALL implement the FSM states IDLE, SHIFT and OUT; in_ready SHALL be 1 only in IDLE.
REQ-017 SHALL accept an operand on in_valid&in_ready; at that edge it loads W=X (zero-extended to NDIG+1 digits), s=0, out_ovf=0 and k_eff=min(in_k,K_MAX).
REQ-018 SHALL go from IDLE to SHIFT on accept when k_eff>0, and from IDLE to OUT on accept when k_eff==0; in the k_eff==0 case out_w=X, out_step=0 and out_last=1.
REQ-019 SHALL, in SHIFT, perform exactly one doubling per clock: W<=2W, s<=s+1, then go to OUT; out_valid SHALL be high from the edge after the SHIFT cycle.
REQ-020 SHALL, in OUT, hold out_valid=1 with out_w, out_step, out_last and out_ovf stable until out_valid&out_ready.
REQ-021 SHALL, on the OUT handshake, go to IDLE if out_last is set, else go to SHIFT.
REQ-022 SHALL produce k_eff+1 beats when k_eff==0 (one beat, s=0) and k_eff beats (s=1..k_eff) when k_eff>0; the first multiple therefore appears 2 edges after accept.
REQ-023 SHALL double each digit as follows: decode the 4221 value v=4b3+2b2+2b1+b0; recode v to 5211 with the table 0:0000, 1:0001, 2:0100, 3:0101, 4:0111, 5:1000, 6:1001, 7:1100, 8:1101, 9:1111; output {c5211[2:0], cin} as the new 4221 digit and c5211[3] as carry-out.
REQ-024 SHALL feed digit i's carry-in from digit i-1's carry-out, with digit 0 carry-in = 0; the whole doubling SHALL be combinational within one cycle.
REQ-025 SHALL OR digit NDIG's carry-out into out_ovf on each doubling; that carry is discarded from W.
REQ-026 SHALL accept every 4-bit in_x code, since every 4221 code is a legal digit 0..9.
REQ-027 SHALL be checked by the verifier on digit values only, because the 4221 code is redundant.
REQ-028 SHALL NOT accept a new operand before the last beat is handshaken, since in_ready=0 outside IDLE.

Reset
REQ-029 SHALL, while rst_n=0, force the state to IDLE, W=0, s=0, k_eff=0, out_valid=0, out_last=0 and out_ovf=0, with in_ready=1 immediately.
REQ-030 SHALL abort any in-progress operation on reset, emitting no further beats; after rst_n rises, the first accept SHALL occur no earlier than the first clk edge.

Structure
REQ-031 SHALL place in package dec_mult_pkg: the state enum, the 5211 recode table constant, and the NDIG/K_MAX defaults.
REQ-032 SHALL use one sub-module, dec_digit_x2_4221 (inputs: 4221 digit and cin; outputs: 4221 digit and cout), instantiated NDIG+1 times in a ripple chain.
REQ-033 SHALL keep the FSM, counters and handshake in the top module.

Verification (NDIG=4 unless noted)
REQ-034 SHALL cover: X=1234, k=3, out_ready=1 -> beats 2468/4936/9872, out_step 1/2/3, out_last only on step 3, out_ovf=0.
REQ-035 SHALL cover: X=9999, k=3 -> beats 19998/39996/79992, out_ovf=0.
REQ-036 SHALL cover: X=0507, k=0 -> a single beat 00507, out_step=0, out_last=1; in_k=7 with K_MAX=3 -> exactly 3 beats.
REQ-037 SHALL cover: X=1234, k=2, out_ready held low 5 cycles on step 1 -> out_w=2468 stays stable, no step-2 beat, then 4936 follows after ready.
REQ-038 SHALL cover: K_MAX=4, X=9999, k=4 -> step 4 out_w value 59984, out_ovf=1; the next operation starts with out_ovf=0.
REQ-039 SHALL cover: rst_n low during SHIFT of step 2 -> out_valid=0 and in_ready=1 asynchronously; the next operand completes correctly.
